// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: chooses hold/advance/redirect for the PC register and
// keeps at most one instruction-memory request in flight, killing it on redirect.
module fetch_ctrl #(
    parameter int PCLEN       = 12,
    parameter int BOOT_CYCLES = 4,
    parameter int CNTW        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EX_taken,
    input  logic [PCLEN-1:0] EX_alt_pc,
    input  logic             EXC_valid,
    input  logic [PCLEN-1:0] EXC_vector,
    input  logic             stall_D,
    input  logic             IC_req_ready,
    input  logic             IC_resp_valid,
    output logic             IC_req_valid,
    output logic             PC_redirect,
    output logic [PCLEN-1:0] PC_redirect_pc,
    output logic             PC_hold,
    output logic             F_valid,
    output logic             F_kill,
    output logic [CNTW-1:0]  redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int BCW = $clog2(BOOT_CYCLES + 1);
    localparam logic [BCW-1:0]  BOOT_LAST = BCW'(BOOT_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    state_t          state_q, state_d;
    logic [BCW-1:0]  boot_cnt_q, boot_cnt_d;
    logic            held_q, held_d;
    logic [CNTW-1:0] redirect_cnt_q, redirect_cnt_d;
    logic            redir_s;

    // Redirect select, next-state and per-cycle handshake outputs
    always_comb begin
        redir_s        = EXC_valid | EX_taken;
        PC_redirect_pc = EXC_valid ? EXC_vector : EX_alt_pc;
        // Redirect strobes are silenced while reset is held
        PC_redirect    = redir_s & rst_n;
        F_kill         = redir_s & rst_n;
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        held_d         = held_q;
        IC_req_valid   = 1'b0;
        PC_hold        = 1'b1;
        F_valid        = 1'b0;
        if (redir_s && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                IC_req_valid = ~stall_D & ~redir_s;
                if (IC_req_valid && IC_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (held_q) begin
                    // Instruction parked in fetch until decode frees up
                    if (redir_s) begin
                        held_d  = 1'b0;
                        state_d = ST_RUN;
                    end else if (!stall_D) begin
                        F_valid = 1'b1;
                        PC_hold = 1'b0;
                        held_d  = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        F_valid = 1'b1;
                    end
                end else if (redir_s) begin
                    state_d = IC_resp_valid ? ST_RUN : ST_DRAIN;
                end else if (IC_resp_valid) begin
                    F_valid = 1'b1;
                    if (stall_D) begin
                        held_d = 1'b1;
                    end else begin
                        PC_hold = 1'b0;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (IC_resp_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, boot counter, held flag and redirect counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_BOOT;
            boot_cnt_q     <= {BCW{1'b0}};
            held_q         <= 1'b0;
            redirect_cnt_q <= {CNTW{1'b0}};
        end else begin
            state_q        <= state_d;
            boot_cnt_q     <= boot_cnt_d;
            held_q         <= held_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch-stage PC register and the instruction-memory request port. It decides each cycle whether the PC holds, advances to the predicted target or is redirected. It issues one outstanding I-mem request at a time and kills in-flight fetches on redirect. It sits between EX/trap logic, decode stall logic, the I-mem port and the PC register.

Parameters:
PCLEN, 12, PC width in bits
BOOT_CYCLES, 4, cycles after reset release before the first fetch (I-mem init), >=1
CNTW, 16, width of the redirect performance counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
EX_taken  input  1  EX branch/jump redirect
EX_alt_pc  input  PCLEN  EX redirect target
EXC_valid  input  1  trap/exception redirect; outranks EX_taken
EXC_vector  input  PCLEN  trap target
stall_D  input  1  decode cannot accept an instruction
IC_req_ready  input  1  I-mem accepts request this cycle
IC_resp_valid  input  1  I-mem returns instruction for the outstanding request
IC_req_valid  output  1  fetch request at current F_pc
PC_redirect  output  1  to PC register EX_taken input
PC_redirect_pc  output  PCLEN  to PC register EX_alt_pc input
PC_hold  output  1  to PC register stall_D input
F_valid  output  1  instruction in fetch is valid for decode
F_kill  output  1  flush fetch/decode pipeline register this cycle
redirect_cnt  output  CNTW  saturating count of redirects forwarded

Behaviour:
- States: BOOT, RUN, WAIT, DRAIN. Registered state, a boot counter, a held-response flag and redirect_cnt.
- Reset (rst_n=0, asynchronous): state=BOOT, boot counter=0, redirect_cnt=0, held flag=0.
- Output values while in reset: IC_req_valid=0, PC_hold=1, F_valid=0, F_kill=0, PC_redirect=0.
- Reset asserted mid-operation abandons any outstanding request. I-mem responses after reset release are ignored in BOOT.
- Redirect select is combinational:
  - redir = EXC_valid | EX_taken.
  - PC_redirect_pc = EXC_valid ? EXC_vector : EX_alt_pc.
  - PC_redirect = redir in every state except reset.
  - F_kill = redir.
  - Each cycle with redir=1 increments redirect_cnt, which saturates at all-ones.
- BOOT:
  - IC_req_valid=0, PC_hold=1.
  - Counter increments each cycle. When it reaches BOOT_CYCLES-1, go to RUN.
  - First request is issued exactly BOOT_CYCLES cycles after rst_n rises.
  - A redirect in BOOT is forwarded (PC loads it) with no state change.
- RUN (nothing outstanding):
  - IC_req_valid = !stall_D & !redir. PC_hold=1. F_valid=0.
  - IC_req_valid & IC_req_ready -> WAIT.
  - A stall_D=1 or redir=1 cycle issues no request.
- WAIT (one request outstanding):
  - IC_req_valid=0.
  - On IC_resp_valid with redir=0:
    - stall_D=0: F_valid=1 and PC_hold=0 (PC advances to BP target) in the same cycle; next state RUN.
    - stall_D=1: set held flag; F_valid=1 and PC_hold=1 each cycle until stall_D=0. In the release cycle, PC_hold=0 and F_valid=1, then clear held flag and go to RUN.
  - redir=1 before the response arrives: go to DRAIN.
  - redir=1 in the response cycle: drop the response (F_valid=0), go to RUN.
  - redir=1 while held: clear held flag, F_valid=0, go to RUN.
- DRAIN:
  - IC_req_valid=0, PC_hold=1, F_valid=0.
  - On IC_resp_valid: discard, go to RUN.
  - Further redirects in DRAIN are forwarded only; stay in DRAIN.
- Invariants:
  - At most one outstanding request.
  - F_valid is never 1 in a cycle with redir=1.
  - PC_hold=0 only in a cycle where F_valid=1 and stall_D=0.
  - A redirect always takes precedence over PC_hold (PC register priority).

Test Plan:
- Reset release, BOOT_CYCLES=4, IC_req_ready=1 -> IC_req_valid first high in cycle 4 after rst_n rises; PC_hold=1 in cycles 0-4.
- Steady fetch, IC_req_ready=1, response 1 cycle after accept, stall_D=0 -> one F_valid pulse every 2 cycles, PC_hold low exactly in each F_valid cycle.
- stall_D=1 for 3 cycles when response arrives -> F_valid high 4 cycles, PC_hold=1 for the first 3, 0 on the 4th, then RUN.
- EX_taken=1, EX_alt_pc=0x100 one cycle after accept, response 2 cycles later -> PC_redirect=1 and PC_redirect_pc=0x100 that cycle; state DRAIN; response discarded (F_valid=0); next request issued the following cycle; redirect_cnt=1.
- EXC_valid=1, EXC_vector=0x040 together with EX_taken=1, EX_alt_pc=0x200 -> PC_redirect_pc=0x040, F_kill=1, redirect_cnt +1.
- rst_n pulsed low while in WAIT with the response arriving after release -> outputs at reset values, response ignored, BOOT count restarts from 0; also, 2^CNTW+3 redirects -> redirect_cnt holds at all-ones.
